// File: rtl/systolic_drain.sv
// systolic_drain: reads the DIM x DIM accumulator array out row by row after a
// compute phase, streams the elements row-major over valid/ready, then issues
// a one-cycle accumulator clear so the next phase starts from zero.

// One column of the row buffer: holds element c of the most recently loaded row.
module systolic_drain_lane #(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [ACC_W-1:0] i_d,
  output logic [ACC_W-1:0] o_q
);
  logic [ACC_W-1:0] r_q;

  // Capture this column of the selected row only during LOAD
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_q <= '0;
    else if (i_load) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

module systolic_drain #(
  parameter int DIM   = 8,
  parameter int ACC_W = 32,
  parameter int IDX_W = $clog2(DIM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 done_i,
  output logic [IDX_W-1:0]     row_sel_o,
  input  logic [DIM*ACC_W-1:0] row_data_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_data,
  output logic [IDX_W-1:0]     out_row,
  output logic [IDX_W-1:0]     out_col,
  output logic                 out_last,
  output logic                 busy_o,
  output logic                 clr_o,
  output logic                 overrun_o
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_CLEAR} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIM - 1);

  state_t                    r_state, w_next;
  logic [IDX_W-1:0]          r_row, r_col;
  logic                      r_ovr;
  logic [DIM-1:0][ACC_W-1:0] w_buf;
  logic                      w_load, w_stream, w_hs, w_col_end, w_row_end;

  // Row buffer: one lane per column, all loaded together from the array mux
  for (genvar c = 0; c < DIM; c++) begin : g_lane
    systolic_drain_lane #(.ACC_W(ACC_W)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load),
      .i_d    (row_data_i[c*ACC_W +: ACC_W]),
      .o_q    (w_buf[c])
    );
  end

  assign w_col_end = (r_col == LAST);
  assign w_row_end = (r_row == LAST);
  // valid comes from state alone, so ready only qualifies the handshake
  assign w_hs      = w_stream & out_ready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state and per-state control outputs
  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_stream = 1'b0;
    clr_o    = 1'b0;
    busy_o   = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (done_i) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_load = 1'b1;
        w_next = S_STREAM;
      end
      S_STREAM: begin
        w_stream = 1'b1;
        if (out_ready && w_col_end) w_next = w_row_end ? S_CLEAR : S_LOAD;
      end
      S_CLEAR: begin
        clr_o  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Row/column walk; col saturates at the row end until LOAD rewinds it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row <= '0;
      r_col <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (done_i) begin
          r_row <= '0;
          r_col <= '0;
        end
        S_LOAD: r_col <= '0;
        S_STREAM: if (w_hs) begin
          if (!w_col_end)      r_col <= r_col + IDX_W'(1);
          else if (!w_row_end) r_row <= r_row + IDX_W'(1);
        end
        S_CLEAR: begin
          r_row <= '0;
          r_col <= '0;
        end
        default: ;
      endcase
    end
  end

  // Sticky flag: a done pulse arrived while a drain was still in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          r_ovr <= 1'b0;
    else if (done_i && r_state != S_IDLE) r_ovr <= 1'b1;
  end

  assign row_sel_o = r_row;
  assign out_valid = w_stream;
  assign out_data  = w_stream ? w_buf[r_col] : '0;
  assign out_row   = w_stream ? r_row : '0;
  assign out_col   = w_stream ? r_col : '0;
  assign out_last  = w_stream & w_col_end & w_row_end;
  assign overrun_o = r_ovr;
endmodule
